// File: rtl/fmap_streamer_if.sv
// Bundles the feature-map SRAM read port and the outgoing pixel stream of fmap_streamer.
interface fmap_streamer_if #(
  parameter int AW = 10,
  parameter int DW = 24
);
  logic [AW-1:0] mem_addr;
  logic          mem_ren;
  logic [DW-1:0] mem_rdata;
  logic          valid;
  logic [DW-1:0] D;
  logic          last;

  modport master (
    output mem_addr, mem_ren, valid, D, last,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_ren, valid, D, last,
    output mem_rdata
  );
endinterface

// File: rtl/fmap_streamer.sv
// Streams one feature map from SRAM in raster order, then PAD all-zero rows,
// as a valid/D pixel stream for the sliding-window line buffer.
module fmap_streamer #(
  parameter int BITWIDTH = 8,
  parameter int NFMAPS   = 3,
  parameter int NW       = 32,
  parameter int NH       = 32,
  parameter int PAD      = 1,
  parameter int AW       = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            pause,
  fmap_streamer_if.master bus,
  output logic            busy,
  output logic            done
);

  localparam int NPIX = NW * NH;
  localparam int NPAD = PAD * NW;
  localparam int PW   = (PAD == 0) ? 1 : $clog2(NPAD + 1);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [PW-1:0] LAST_PAD  = PW'((NPAD == 0) ? 0 : NPAD - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    PAD_ROWS,
    FINISH
  } state_e;

  state_e                      state_q, state_d;
  logic [AW-1:0]               addr_q, addr_d;
  logic [PW-1:0]               pad_cnt_q, pad_cnt_d;
  logic                        valid_q, valid_d;
  logic                        pad_q, pad_d;
  logic                        last_q, last_d;
  logic                        issue_px;
  logic [NFMAPS*BITWIDTH-1:0]  rdata;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pad_cnt_d = pad_cnt_q;
    valid_d   = 1'b0;
    pad_d     = 1'b0;
    last_d    = 1'b0;
    issue_px  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) state_d = STREAM;
      end

      STREAM: begin
        // The final beat drains through the output register before FINISH,
        // so done lands in the cycle after the last valid beat.
        if (last_q) begin
          state_d = FINISH;
        end else if (!pause) begin
          issue_px = 1'b1;
          valid_d  = 1'b1;
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            last_d = (PAD == 0);
            if (PAD != 0) state_d = PAD_ROWS;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end

      PAD_ROWS: begin
        if (last_q) begin
          state_d = FINISH;
        end else if (!pause) begin
          valid_d = 1'b1;
          pad_d   = 1'b1;
          if (pad_cnt_q == LAST_PAD) begin
            pad_cnt_d = '0;
            last_d    = 1'b1;
          end else begin
            pad_cnt_d = pad_cnt_q + 1'b1;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      pad_cnt_q <= '0;
      valid_q   <= 1'b0;
      pad_q     <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pad_cnt_q <= pad_cnt_d;
      valid_q   <= valid_d;
      pad_q     <= pad_d;
      last_q    <= last_d;
    end
  end

  assign rdata        = bus.mem_rdata;
  assign bus.mem_ren  = issue_px;
  assign bus.mem_addr = addr_q;
  assign bus.valid    = valid_q;
  assign bus.last     = last_q;
  assign bus.D        = (valid_q && !pad_q) ? rdata : '0;

  assign busy = (state_q != IDLE);
  assign done = (state_q == FINISH);

endmodule
